// File: rtl/retire_trace_buf.sv
// Retirement-trace capture: packs each retiring event into a FWFT FIFO drained over valid/ready.
// Head data visible 1 cycle after push; a push into a full FIFO without a pop is dropped and flagged.
module retire_trace_buf #(
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 100000,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      pc,
  input  logic             reg_write,
  input  logic [3:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_store_data,
  input  logic [15:0]      mem_load_data,
  input  logic             halt,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [3:0]       rd_flags,
  output logic [15:0]      rd_pc,
  output logic [3:0]       rd_reg,
  output logic [15:0]      rd_reg_data,
  output logic [15:0]      rd_addr,
  output logic [15:0]      rd_mem_data,
  output logic             overflow,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] INST_SAT  = {CNT_W{1'b1}};

  typedef struct packed {
    logic [3:0]  flags;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] reg_data;
    logic [15:0] addr;
    logic [15:0] mem_data;
  } entry_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_TIMEOUT} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  entry_t           mem_q [DEPTH];

  entry_t in_entry;
  entry_t head;
  logic   capture;
  logic   event_vld;
  logic   fifo_empty;
  logic   fifo_full;
  logic   pop;
  logic   push;
  logic   drop;

  always_comb begin
    in_entry.flags    = {halt, mem_write, mem_read, reg_write};
    in_entry.pc       = pc;
    in_entry.rd       = write_reg;
    in_entry.reg_data = write_data;
    in_entry.addr     = mem_addr;
    in_entry.mem_data = mem_write ? mem_store_data : mem_load_data;
  end

  assign capture    = (state_q == S_RUN);
  assign event_vld  = capture & (reg_write | mem_read | mem_write | halt);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = event_vld & (!fifo_full | pop);
  assign drop       = event_vld & fifo_full & !pop;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q | drop;
    cyc_d      = cyc_q;
    inst_d     = inst_q;
    if (capture && cyc_q != CYC_LIMIT) begin
      cyc_d = cyc_q + 1'b1;
    end
    if (capture && (halt | reg_write | mem_write) && inst_q != INST_SAT) begin
      inst_d = inst_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      inst_q     <= '0;
      cyc_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      inst_q     <= inst_d;
      cyc_q      <= cyc_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Watchdog expiry is checked before halt so TIMEOUT wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (cyc_d == CYC_LIMIT) begin
          state_d = S_TIMEOUT;
        end else if (event_vld && halt) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_DONE;
      S_TIMEOUT: state_d = S_TIMEOUT;
      default:   state_d = S_RUN;
    endcase
  end

  always_comb begin
    done    = (state_q == S_DONE);
    timeout = (state_q == S_TIMEOUT);
  end

  always_comb begin
    head = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  assign rd_valid    = !fifo_empty;
  assign rd_flags    = head.flags;
  assign rd_pc       = head.pc;
  assign rd_reg      = head.rd;
  assign rd_reg_data = head.reg_data;
  assign rd_addr     = head.addr;
  assign rd_mem_data = head.mem_data;
  assign overflow    = overflow_q;
  assign inst_count  = inst_q;
  assign cycle_count = cyc_q;

endmodule

// File: doc/retire_trace_buf.md
Name: retire_trace_buf

Overview:
Hardware retirement-trace capture stage that sits directly downstream of cpu2's writeback/memory stage. Each cycle it samples the retiring instruction's register-write, memory-access and halt signals and packs any non-null event into a FIFO. It also maintains instruction and cycle counters and a run/drain/done/timeout state machine. A host or debug port drains the FIFO over a valid/ready interface, so retirement traces can be captured on silicon/FPGA, not only in simulation.

Parameters:
DEPTH, 16, FIFO entries; power of two, >=2.
MAX_CYCLES, 100000, watchdog limit on cycle_count.
CNT_W, 32, width of inst_count and cycle_count.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, synchronous, active-low.
pc  in  16  PC of retiring instruction.
reg_write  in  1  register file written this cycle.
write_reg  in  4  destination register.
write_data  in  16  data written to register.
mem_read  in  1  load retiring this cycle.
mem_write  in  1  store retiring this cycle.
mem_addr  in  16  memory address (load or store).
mem_store_data  in  16  data written to memory.
mem_load_data  in  16  data read from memory.
halt  in  1  halt in memory/writeback stage.
rd_valid  out  1  FIFO head valid.
rd_ready  in  1  consumer accepts head.
rd_flags  out  4  {halt, store, load, reg} of head entry.
rd_pc  out  16  head PC.
rd_reg  out  4  head write_reg.
rd_reg_data  out  16  head write_data.
rd_addr  out  16  head mem_addr.
rd_mem_data  out  16  head store data if store flag, else load data.
overflow  out  1  sticky: an event was dropped.
inst_count  out  CNT_W  retired-instruction count.
cycle_count  out  CNT_W  cycles since reset release.
done  out  1  halt seen and FIFO fully drained.
timeout  out  1  watchdog expired.

Behaviour:
- Reset (rst_n=0 at a rising edge): FIFO empty; rd_valid=0; all rd_* data outputs 0; overflow=0; inst_count=0; cycle_count=0; done=0; timeout=0; state=RUN. A reset mid-operation discards all FIFO contents.
- States:
  - RUN: capture enabled. halt event -> DRAIN, taking effect on the same edge the halt entry is written. cycle_count reaching MAX_CYCLES -> TIMEOUT.
  - DRAIN: capture disabled; FIFO keeps draining. FIFO empty -> DONE.
  - DONE: done=1; terminal until reset.
  - TIMEOUT: timeout=1; capture disabled; FIFO still drainable; terminal until reset.
  - If halt and watchdog expiry occur in the same cycle, TIMEOUT wins and the halt entry is still pushed.
- Event detection (RUN only): event = reg_write|mem_read|mem_write|halt. Each event cycle pushes exactly one entry with flags {halt, mem_write, mem_read, reg_write} and all data fields latched. A load with register writeback is therefore one entry with load and reg flags set. mem_data field = mem_write ? mem_store_data : mem_load_data.
- Counters, RUN only:
  - cycle_count +1 per cycle, saturating at MAX_CYCLES.
  - inst_count +1 when halt|reg_write|mem_write, saturating at all-ones.
  - Both freeze in DRAIN, DONE and TIMEOUT.
- FIFO: first-word-fall-through; rd_* reflect the head combinationally from storage, so head data is valid the cycle after the push (1-cycle latency).
  - Pop occurs when rd_valid&rd_ready; rd_ready while empty has no effect.
  - Push and pop in the same cycle are both honoured, including when full (pop frees the slot) and when empty (entry appears next cycle; no bypass).
  - Push while full with no pop: entry dropped, overflow set (sticky until reset); counters still update.
  - Pointers wrap modulo DEPTH; a full/empty distinction uses an extra pointer bit.
- rd_valid only drops after a pop of the last entry; rd_* data is held while rd_valid=1 and rd_ready=0.

Test Plan:
- Reset release, then reg_write=1, write_reg=3, write_data=0x00A5, pc=0x0004 for 1 cycle -> next cycle rd_valid=1, rd_flags=0001, rd_reg=3, rd_reg_data=0x00A5, rd_pc=0x0004; inst_count=1.
- Load cycle: mem_read=1, reg_write=1, mem_addr=0x0010, mem_load_data=0xBEEF, write_reg=5 -> single entry, rd_flags=0011, rd_addr=0x0010, rd_mem_data=0xBEEF; inst_count unchanged by mem_read alone.
- rd_ready=0 for 17 consecutive reg_write events with DEPTH=16 -> 16 entries held, overflow=1, inst_count=17. Then rd_ready=1 -> exactly 16 entries pop in order, followed by rd_valid=0.
- Full FIFO with simultaneous push and pop -> occupancy stays 16, overflow stays 0, new entry appears last.
- halt=1 with 2 entries queued -> halt entry pushed (flags 1000); subsequent reg_write is ignored; after 3 pops, done=1; counters frozen.
- MAX_CYCLES=50 with no halt -> timeout=1 at cycle_count=50; events ignored after that; rst_n=0 for one edge -> every output returns to its reset value.
